// File: rtl/motor_pkg.sv
// Shared types and helpers for the pump motor channels.
package motor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    RUN,
    BRAKE
  } state_t;

  localparam int PWM_W = 8;

  // Width of a counter spanning one millisecond of clocks.
  function automatic int ms_w(input int clk_hz);
    int n;
    n = clk_hz / 1000;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/motor_dispense_ctrl_ms_tick.sv
// Restartable millisecond strobe, shared by the pump channels.
module ms_tick
  import motor_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int DIV = CLK_HZ / 1000;
  localparam int W   = ms_w(CLK_HZ);

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/motor_dispense_ctrl.sv
// Timed H-bridge pump driver: PWM drive, then active brake, then done.
// Soft-start ramp is built only when MOTOR_SOFT_START_EN is defined.
module motor_dispense_ctrl
  import motor_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int PRESCALE  = 16,
  parameter int RAMP_STEP = 16,
  parameter int BRAKE_MS  = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PWM_W-1:0] duty,
  input  logic [15:0]      dur_ms,
  input  logic             dir,
  output logic             in1,
  output logic             in2,
  output logic             enA,
  output logic             busy,
  output logic             done
);

`ifdef MOTOR_SOFT_START_EN
  localparam state_t START_ST = RAMP;
  localparam logic   SOFT     = 1'b1;
`else
  localparam state_t START_ST = RUN;
  localparam logic   SOFT     = 1'b0;
`endif

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  state_t           state;
  logic [PWM_W-1:0] tgt;
  logic [PWM_W-1:0] cur_duty;
  logic [PWM_W-1:0] pwm_cnt;
  logic [PS_W-1:0]  pre;
  logic [15:0]      rem_ms;
  logic [15:0]      brk_cnt;

  logic             tick;
  logic             restart;
  logic             accept;
  logic             driving;
  logic             to_brake;
  logic             brk_last;
  logic             pwm_step;
  logic [PS_W-1:0]  pre_nxt;
  logic [PWM_W-1:0] pwm_nxt;
  logic [PWM_W-1:0] duty_nxt;
  logic [PWM_W:0]   ramp_sum;
  logic [PWM_W-1:0] ramp_val;

  assign accept   = (state == IDLE) && start && !abort
                    && (dur_ms != '0);
  assign driving  = (state == RAMP) || (state == RUN);
  assign to_brake = driving
                    && (abort || (tick && rem_ms == 16'd1));
  assign brk_last = (state == BRAKE) && tick
                    && (brk_cnt == 16'(BRAKE_MS - 1));
  assign restart  = accept || to_brake;

  ms_tick #(
    .CLK_HZ(CLK_HZ)
  ) u_ms (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .tick   (tick)
  );

  always_comb begin
    pwm_step = (pre == PS_W'(PRESCALE - 1));
    pre_nxt  = pwm_step ? '0 : pre + 1'b1;
    pwm_nxt  = pwm_step ? pwm_cnt + 1'b1 : pwm_cnt;
    if (accept) begin
      pre_nxt = '0;
      pwm_nxt = '0;
    end
  end

  // Ramp sum is one bit wider so a step past 255 saturates.
  always_comb begin
    ramp_sum = {1'b0, cur_duty} + 9'(RAMP_STEP);
    ramp_val = (ramp_sum > {1'b0, tgt}) ? tgt
                                        : ramp_sum[PWM_W-1:0];
    duty_nxt = cur_duty;
    if (accept) begin
      duty_nxt = SOFT ? '0 : duty;
    end else if (state == RAMP && tick) begin
      duty_nxt = ramp_val;
    end else if (brk_last) begin
      duty_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tgt      <= '0;
      cur_duty <= '0;
      pwm_cnt  <= '0;
      pre      <= '0;
      rem_ms   <= '0;
      brk_cnt  <= '0;
      in1      <= 1'b0;
      in2      <= 1'b0;
      enA      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done     <= 1'b0;
      cur_duty <= duty_nxt;
      pwm_cnt  <= pwm_nxt;
      pre      <= pre_nxt;
      unique case (state)
        IDLE: begin
          if (accept) begin
            state  <= START_ST;
            tgt    <= duty;
            rem_ms <= dur_ms;
            busy   <= 1'b1;
            in1    <= dir;
            in2    <= ~dir;
            enA    <= (pwm_nxt < duty_nxt);
          end else if (start && !abort) begin
            done <= 1'b1;
          end
        end
        RAMP, RUN: begin
          if (to_brake) begin
            state   <= BRAKE;
            brk_cnt <= '0;
            in1     <= 1'b0;
            in2     <= 1'b0;
            enA     <= 1'b1;
          end else begin
            if (tick) begin
              rem_ms <= rem_ms - 1'b1;
            end
            if (state == RAMP && duty_nxt == tgt) begin
              state <= RUN;
            end
            enA <= (pwm_nxt < duty_nxt);
          end
        end
        BRAKE: begin
          if (tick) begin
            if (brk_last) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
              enA   <= 1'b0;
            end else begin
              brk_cnt <= brk_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule
